// File: rtl/alu_multicycle.sv
// Handshaked WIDTH-bit ALU with registered result/flags; single-cycle ops plus an
// optional shift-add multiplier compiled in with ALU_MUL_EN.
module alu_multicycle #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);
  // state  | meaning
  // S_IDLE | ready; single-cycle ops complete here, MUL is launched from here
  // S_MUL  | one shift-add step per cycle, exits when the down-counter hits 0

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NOP  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_SAR  = 4'd12;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign shamt    = srcB[SHW-1:0];
  assign add_full = {1'b0, srcA} + {1'b0, srcB};
  assign sub_full = {1'b0, srcA} - {1'b0, srcB};

  // Reserved codes (and MUL when not built in) fall through to result 0.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (srcA[MSB] == srcB[MSB]) && (add_full[MSB] != srcA[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (srcA[MSB] != srcB[MSB]) && (sub_full[MSB] != srcA[MSB]);
      end
      OP_AND:  alu_res = srcA & srcB;
      OP_OR:   alu_res = srcA | srcB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      OP_NOT:  alu_res = ~srcB;
      OP_NOP:  alu_res = srcA;
      OP_XOR:  alu_res = srcA ^ srcB;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, srcA < srcB};
      OP_SHL:  alu_res = srcA << shamt;
      OP_SHR:  alu_res = srcA >> shamt;
      OP_SAR:  alu_res = $unsigned($signed(srcA) >>> shamt);
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL   = 4'd13;
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] result_hi_q;
  logic [SHW:0]     cnt;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  // acc_lo starts as the multiplier and fills with product bits as it shifts out.
  assign step_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign next_hi   = step_sum[WIDTH:1];
  assign next_lo   = {step_sum[0], acc_lo[WIDTH-1:1]};
  assign in_ready  = (state == S_IDLE);
  assign result_hi = result_hi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mcand       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi_q <= '0;
      zero        <= 1'b1;
      carry       <= 1'b0;
      negative    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              mcand  <= srcA;
              acc_lo <= srcB;
              acc_hi <= '0;
              cnt    <= CNT_INIT;
              state  <= S_MUL;
            end else begin
              out_valid   <= 1'b1;
              result      <= alu_res;
              result_hi_q <= '0;
              zero        <= (alu_res == '0);
              carry       <= alu_c;
              negative    <= alu_res[MSB];
              overflow    <= alu_v;
            end
          end
        end
        S_MUL: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state       <= S_IDLE;
            out_valid   <= 1'b1;
            result      <= next_lo;
            result_hi_q <= next_hi;
            zero        <= ({next_hi, next_lo} == '0);
            carry       <= (next_hi != '0);
            negative    <= next_lo[MSB];
            overflow    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign in_ready  = 1'b1;
  assign result_hi = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        carry    <= alu_c;
        negative <= alu_res[MSB];
        overflow <= alu_v;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Randomized self-checking bench for alu_multicycle (WIDTH=8) against an
// arithmetic reference model; MUL scenarios run when ALU_MUL_EN is defined.
module tb_alu_multicycle;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] srcA;
  logic [7:0] srcB;
  logic       out_valid;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       zero, carry, negative, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_r, exp_hi;
  logic       exp_z, exp_c, exp_n, exp_v;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  alu_multicycle #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .srcA(srcA), .srcB(srcB), .out_valid(out_valid),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
    .negative(negative), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [7:0] hi,
                       output logic z, output logic c, output logic n, output logic v);
    int ua, ub, sa, sb, s, t;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    s  = ub % 8;
    r = 8'h00; hi = 8'h00; c = 1'b0; v = 1'b0;
    case (o)
      4'd0: begin t = ua + ub; r = t[7:0]; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin t = ua - ub; r = t[7:0]; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = (sa < sb) ? 8'd1 : 8'd0;
      4'd5: r = ~b;
      4'd7: r = a;
      4'd8: r = a ^ b;
      4'd9: r = (ua < ub) ? 8'd1 : 8'd0;
      4'd10: begin t = ua << s; r = t[7:0]; end
      4'd11: begin t = ua >> s; r = t[7:0]; end
      4'd12: begin t = sa >>> s; r = t[7:0]; end
      4'd13: if (MUL_EN) begin t = ua * ub; r = t[7:0]; hi = t[15:8]; c = (hi != 0); end
      default: ;
    endcase
    z = (r == 0) && (hi == 0);
    n = r[7];
  endtask

  task automatic check_fields(input string tag);
    chk({tag, " result"},    result,    exp_r);
    chk({tag, " result_hi"}, result_hi, exp_hi);
    chk({tag, " zero"},      zero,      exp_z);
    chk({tag, " carry"},     carry,     exp_c);
    chk({tag, " negative"},  negative,  exp_n);
    chk({tag, " overflow"},  overflow,  exp_v);
  endtask

  task automatic expect_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    string tag;
    tag = $sformatf("op%0d %02h,%02h", o, a, b);
    model(o, a, b, exp_r, exp_hi, exp_z, exp_c, exp_n, exp_v);
    chk({tag, " out_valid"}, out_valid, 1);
    check_fields(tag);
  endtask

  // Single-cycle op: present, accept on the next edge, check in the following cycle.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    op = o; srcA = a; srcB = b; in_valid = 1'b1;
    chk("in_ready before accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_op(o, a, b);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle out_valid", out_valid, 0);
    chk("idle in_ready", in_ready, 1);
    check_fields("hold");
  endtask

  task automatic set_reset_expect();
    exp_r = 8'h00; exp_hi = 8'h00; exp_z = 1'b1; exp_c = 1'b0; exp_n = 1'b0; exp_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] o;
    logic [7:0] a, b;
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; srcA = 8'h00; srcB = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    set_reset_expect();
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    check_fields("reset");

    issue(4'd0, 8'hFF, 8'h01);
    chk("add ff+01 result", result, 8'h00);
    chk("add ff+01 carry", carry, 1);
    issue(4'd1, 8'h80, 8'h01);
    chk("sub 80-01 overflow", overflow, 1);
    issue(4'd1, 8'h01, 8'h02);
    chk("sub 01-02 carry", carry, 1);
    idle_cycle();

    // back-to-back compares and shifts
    issue(4'd4,  8'h80, 8'h01);
    issue(4'd9,  8'h80, 8'h01);
    issue(4'd12, 8'h90, 8'h02);
    chk("sar result", result, 8'hE4);
    issue(4'd11, 8'h90, 8'h02);
    issue(4'd10, 8'h81, 8'h09);
    chk("shl mod width result", result, 8'h02);
    idle_cycle();

    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 15));
      if (MUL_EN && o == 4'd13) o = 4'd8;
      a = 8'($urandom); b = 8'($urandom);
      issue(o, a, b);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

`ifdef ALU_MUL_EN
    begin
      int n;
      op = 4'd13; srcA = 8'hFF; srcB = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      op = 4'd0; srcA = 8'h01; srcB = 8'h02;
      for (int k = 1; k <= 8; k++) begin
        chk("mul busy in_ready", in_ready, 0);
        chk("mul busy out_valid", out_valid, 0);
        check_fields("mul busy hold");
        @(posedge clk); #1;
      end
      expect_op(4'd13, 8'hFF, 8'hFF);
      chk("mul ff*ff result_hi", result_hi, 8'hFE);
      chk("mul done in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_op(4'd0, 8'h01, 8'h02);

      for (int i = 0; i < 12; i++) begin
        a = 8'($urandom); b = 8'($urandom);
        if (i == 0) b = 8'h00;
        op = 4'd13; srcA = a; srcB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk("mul latency", n, 9);
        expect_op(4'd13, a, b);
      end

      op = 4'd13; srcA = 8'h0F; srcB = 8'h11; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1; in_valid = 1'b1; op = 4'd0; srcA = 8'h05; srcB = 8'h06;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      set_reset_expect();
      chk("mid-mul reset out_valid", out_valid, 0);
      chk("mid-mul reset in_ready", in_ready, 1);
      check_fields("mid-mul reset");
      for (int k = 0; k < 10; k++) idle_cycle();
    end
`else
    issue(4'd13, 8'h03, 8'h05);
    chk("op13 reserved result", result, 8'h00);
    chk("op13 reserved zero", zero, 1);
    idle_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
